clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 106 ++++++++++
 tb/tb_clock_period_meter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
// Measures the period and high time of an asynchronous divided clock (dclk)
// in system clock cycles, with saturation/timeout reporting when dclk stops.
module clock_period_meter #(
  parameter int Width      = 16,
  parameter int SyncStages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dclk,
  output logic [Width-1:0] period,
  output logic [Width-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;

  localparam logic [Width-1:0] MAX = '1;
  localparam logic [Width-1:0] ONE = {{(Width-1){1'b0}}, 1'b1};

  logic [SyncStages-1:0] sync;
  logic                  dly;
  logic                  dclk_s;
  logic                  rise;
  logic [1:0]            state;
  logic [Width-1:0]      cnt;
  logic [Width-1:0]      hcnt;

  assign dclk_s = sync[SyncStages-1];
  assign rise   = dclk_s & ~dly;

  // Synchronizer keeps running while disabled so edge detection is fresh on re-enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SyncStages-2:0], dclk};
      dly  <= dclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            // Time before the first edge is not a full period; start clean.
            if (rise) begin
              cnt     <= ONE;
              hcnt    <= ONE;
              stalled <= 1'b0;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hcnt;
              valid     <= 1'b1;
              cnt       <= ONE;
              hcnt      <= ONE;
            end else if (cnt == MAX) begin
              period    <= MAX;
              high_time <= hcnt;
              valid     <= 1'b1;
              stalled   <= 1'b1;
              state     <= TIMEOUT;
            end else begin
              cnt <= cnt + ONE;
              if (dclk_s && hcnt != MAX) hcnt <= hcnt + ONE;
            end
          end
          TIMEOUT: begin
            // Partial interval since the stall is meaningless; restart on the edge.
            if (rise) begin
              cnt     <= ONE;
              hcnt    <= ONE;
              stalled <= 1'b0;
              state   <= MEASURE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
`timescale 1ns/1ps
// Scoreboard bench for clock_period_meter: directed dclk waveforms push expected
// period/high_time pairs; monitors pop and compare on every valid pulse.
module tb_clock_period_meter;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, dclk = 1'b0, en4 = 1'b0, dclk4 = 1'b0;
  logic [15:0] period, high_time;
  logic        valid, stalled;
  logic [3:0]  period4, high4;
  logic        valid4, stalled4;

  always #5 clk = ~clk;

  clock_period_meter #(.Width(16), .SyncStages(2)) u16 (
    .clk(clk), .rst(rst), .en(en), .dclk(dclk),
    .period(period), .high_time(high_time), .valid(valid), .stalled(stalled));

  clock_period_meter #(.Width(4), .SyncStages(2)) u4 (
    .clk(clk), .rst(rst), .en(en4), .dclk(dclk4),
    .period(period4), .high_time(high4), .valid(valid4), .stalled(stalled4));

  typedef struct { int pmin; int pmax; int hmin; int hmax; } exp_t;
  exp_t q16[$];
  exp_t q4[$];

  int errors = 0, checks = 0;
  int cyc = 0, last_vcyc = -1, off_valids = 0, ph = 0;
  bit spacing_on = 1'b0, no_valid_win = 1'b0;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (no_valid_win) off_valids++;
        if (q16.size() == 0) chk("unexpected valid16", 1, 0, 0);
        else begin
          e = q16.pop_front();
          chk("period16", int'(period), e.pmin, e.pmax);
          chk("high16", int'(high_time), e.hmin, e.hmax);
        end
        if (spacing_on && last_vcyc >= 0) chk("spacing16", cyc - last_vcyc, 8, 8);
        last_vcyc = cyc;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid4) begin
        if (q4.size() == 0) chk("unexpected valid4", 1, 0, 0);
        else begin
          e = q4.pop_front();
          chk("period4", int'(period4), e.pmin, e.pmax);
          chk("high4", int'(high4), e.hmin, e.hmax);
        end
      end
    end
  end

  task automatic step_en(input int p, input int h, input logic e);
    @(posedge clk); #1;
    en   = e;
    dclk = (ph < h);
    ph   = (ph + 1 == p) ? 0 : ph + 1;
  endtask

  task automatic step(input int p, input int h);
    step_en(p, h, en);
  endtask

  task automatic wave(input int p, input int h, input int n);
    repeat (n * p) step(p, h);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      dclk = 1'b0;
    end
  endtask

  task automatic rearm();
    @(posedge clk); #1;
    en = 1'b0; dclk = 1'b0;
    idle(3);
    @(posedge clk); #1;
    en = 1'b1;
    idle(3);
    ph = 0;
  endtask

  task automatic push16(input int p, input int h, input int n);
    repeat (n) q16.push_back('{p, p, h, h});
  endtask

  task automatic drain16(input string name);
    idle(12);
    chk(name, q16.size(), 0, 0);
  endtask

  task automatic step4(input logic d);
    @(posedge clk); #1;
    dclk4 = d;
  endtask

  initial begin
    longint t0, tr, tf;
    int jr, jf;

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    chk("rst period16", int'(period), 0, 0);
    chk("rst high16", int'(high_time), 0, 0);
    chk("rst valid16", int'(valid), 0, 0);
    chk("rst stalled16", int'(stalled), 0, 0);
    chk("rst period4", int'(period4), 0, 0);
    chk("rst stalled4", int'(stalled4), 0, 0);
    rst = 1'b1; en = 1'b1;
    idle(3);
    ph = 0;

    // Steady 8/4: six rises, five results, eight cycles apart
    push16(8, 4, 5);
    spacing_on = 1'b1; last_vcyc = -1;
    wave(8, 4, 6);
    drain16("drain steady");
    spacing_on = 1'b0;
    chk("stalled16 steady", int'(stalled), 0, 0);

    // 10/3 switching to 6/3
    rearm();
    push16(10, 3, 4);
    push16(6, 3, 3);
    wave(10, 3, 4);
    wave(6, 3, 4);
    drain16("drain switch");

    // en dropped for 20 cycles, coincident with a rise reaching the FSM
    rearm();
    push16(8, 4, 5);
    wave(8, 4, 3);
    repeat (2) step_en(8, 4, 1'b1);
    step_en(8, 4, 1'b0);
    no_valid_win = 1'b1;
    repeat (19) step_en(8, 4, 1'b0);
    step_en(8, 4, 1'b1);
    no_valid_win = 1'b0;
    repeat (33) step_en(8, 4, 1'b1);
    drain16("drain en-drop");
    chk("valids while en=0", off_valids, 0, 0);

    // Asynchronous reset mid-measurement
    rearm();
    push16(8, 4, 2);
    wave(8, 4, 3);
    idle(4);
    chk("pre-reset queue", q16.size(), 0, 0);
    chk("pre-reset period16", int'(period), 8, 8);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async rst period16", int'(period), 0, 0);
    chk("async rst high16", int'(high_time), 0, 0);
    chk("async rst valid16", int'(valid), 0, 0);
    chk("async rst stalled16", int'(stalled), 0, 0);
    idle(2);
    @(posedge clk); #3;
    rst = 1'b1;
    idle(2);
    ph = 0;
    push16(8, 4, 2);
    wave(8, 4, 3);
    drain16("drain post-reset");

    // Asynchronous jittered dclk, nominal 12 cycles / 6 high
    rearm();
    repeat (9) q16.push_back('{11, 13, 5, 7});
    @(negedge clk);
    t0 = $time;
    for (int k = 0; k < 10; k++) begin
      jr = int'($urandom_range(8)) - 4;
      jf = int'($urandom_range(8)) - 4;
      tr = t0 + 120 * (k + 1) + jr;
      tf = t0 + 120 * (k + 1) + 60 + jf;
      #(tr - $time);
      dclk = 1'b1;
      #(tf - $time);
      dclk = 1'b0;
    end
    drain16("drain jitter");

    // Width=4 stall, recovery, true period
    @(posedge clk); #1;
    en4 = 1'b1;
    repeat (3) step4(1'b0);
    q4.push_back('{15, 15, 4, 4});
    repeat (4) step4(1'b1);
    repeat (40) step4(1'b0);
    chk("stalled4 set", int'(stalled4), 1, 1);
    chk("timeout queue4", q4.size(), 0, 0);
    q4.push_back('{7, 7, 3, 3});
    repeat (3) step4(1'b1);
    repeat (4) step4(1'b0);
    chk("stalled4 cleared", int'(stalled4), 0, 0);
    repeat (3) step4(1'b1);
    repeat (4) step4(1'b0);
    @(posedge clk); #1;
    en4 = 1'b0;
    repeat (10) step4(1'b0);
    chk("recover queue4", q4.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
